simple_io_bridge: RTL
=====================

# simple_io_bridge

Peripheral end of the SIMPLE processor's IN/OUT port protocol. The CPU issues single-cycle IN/OUT strobes. This block answers IN requests from a host-filled input FIFO and accepts OUT words into a host-drained output FIFO. It stalls the CPU whenever the needed FIFO cannot serve the request, and keeps the last output word on a latch for the segment-LED display path.

## Interface
- DEPTH, 8, entries per FIFO; power of two, at least 2
- AW, 3, log2(DEPTH)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_in_req  in  1  one-cycle pulse: CPU executes IN
- cpu_in_data  out  16  word returned to the CPU; valid while cpu_in_ack=1
- cpu_in_ack  out  1  one-cycle pulse: cpu_in_data valid
- cpu_out_req  in  1  one-cycle pulse: CPU executes OUT
- cpu_out_data  in  16  word from the CPU; sampled when cpu_out_req=1
- cpu_stall  out  1  CPU must hold its phase counter while high
- host_push  in  1  push host_wdata into the input FIFO
- host_wdata  in  16  host word for the CPU
- host_pop  in  1  pop the output FIFO head
- host_rdata  out  16  output FIFO head (show-ahead)
- host_rvalid  out  1  output FIFO non-empty
- in_count  out  AW+1  input FIFO occupancy
- out_count  out  AW+1  output FIFO occupancy
- in_ovf  out  1  sticky: host_push attempted while input FIFO full
- out_latch  out  16  last word accepted from the CPU

## Operation
- Two circular FIFOs, DEPTH entries each. Pointers are AW bits and wrap modulo DEPTH. Occupancy counters are AW+1 bits, range 0..DEPTH.
- Input FIFO:
  - host_push when in_count<DEPTH: writes the word and increments.
  - host_push when in_count==DEPTH: word dropped, in_ovf set; only rst clears it.
  - A push and a pop in the same cycle leave the count unchanged.
- Output FIFO:
  - host_pop when out_count==0 is ignored.
  - host_rdata = mem[rd_ptr]; it holds its value while empty.
- FSM states: IDLE, IN_WAIT, OUT_WAIT. cpu_stall = (state != IDLE), registered.
- IDLE + cpu_in_req:
  - Input FIFO non-empty (current count; a same-cycle host_push does not count): pop. Next cycle cpu_in_ack=1 and cpu_in_data=head. Stay in IDLE.
  - Input FIFO empty: go to IN_WAIT.
- IN_WAIT: on the first cycle with in_count>0, pop. Next cycle ack=1, data valid, state IDLE.
- IDLE + cpu_out_req:
  - out_count<DEPTH: push cpu_out_data and load out_latch with it.
  - Full: capture it in a hold register and go to OUT_WAIT. A same-cycle host_pop does not make room.
- OUT_WAIT: on the first cycle with out_count<DEPTH, push the hold register, load out_latch, go to IDLE.
- cpu_in_req and cpu_out_req together in IDLE: IN wins and the OUT is ignored (illegal CPU behaviour).
- Requests arriving in a non-IDLE state are ignored.
- cpu_in_data holds its last value between acks.

## Timing
- Reset values (cycle after rst=1):
  - state IDLE; pointers and counts 0; cpu_stall=0; cpu_in_ack=0
  - cpu_in_data=0; out_latch=0; in_ovf=0; host_rvalid=0; host_rdata=mem[0]
- rst mid-operation: aborts any wait. The held OUT word is discarded and FIFO contents are lost.
- IN latency, data present: req at edge N, ack high in cycle N+1.
- IN latency, FIFO empty: stall high from N+1. Host push at edge M makes in_count>0 in M+1. Pop at M+1, ack and stall=0 at M+2.
- OUT latency: req at N; out_count, host_rvalid and out_latch update in N+1.
- Full OUT: stall high from N+1. Host pop at edge M, push at M+1, stall=0 and out_latch updated in M+2.
- Counts and flags are registered. There are no combinational paths from inputs to outputs, except host_rdata following the read pointer.

## Test plan
- Reset, host pushes 0x1234 and 0xABCD, then cpu_in_req twice (3 cycles apart) -> ack pulses with data 0x1234 then 0xABCD, one cycle after each req; in_count 2→1→0; cpu_stall never high.
- cpu_in_req with empty FIFO, host pushes 0x00FF 5 cycles later -> cpu_stall high for 6 cycles, then ack=1 with 0x00FF and stall=0 in the same cycle.
- 9 cpu_out_req writes 0x0001..0x0009 with DEPTH=8 -> first 8 are queued, out_latch=0x0008, stall on the 9th; a host_pop returns 0x0001, then 0x0009 is queued, out_latch=0x0009, stall drops, out_count=8.
- 9 host_push with no CPU activity -> in_count=8, in_ovf=1; after 8 IN requests the values are the first 8 pushed in order and in_ovf is still 1.
- Wrap-around: 20 interleaved push/pop pairs on both FIFOs -> FIFO order preserved, counts never exceed 1.
- rst asserted while in IN_WAIT with out_count=3 -> next cycle stall=0, counts 0, host_rvalid=0, in_ovf=0, no ack.

Source files
------------

// File: rtl/simple_io_bridge.sv
// simple_io_bridge: CPU IN/OUT port peripheral with host-side FIFOs.
// Stalls the CPU while the needed FIFO cannot serve, and latches the last OUT word.
module simple_io_bridge #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_in_req,
  output logic [15:0]   cpu_in_data,
  output logic          cpu_in_ack,
  input  logic          cpu_out_req,
  input  logic [15:0]   cpu_out_data,
  output logic          cpu_stall,
  input  logic          host_push,
  input  logic [15:0]   host_wdata,
  input  logic          host_pop,
  output logic [15:0]   host_rdata,
  output logic          host_rvalid,
  output logic [AW:0]   in_count,
  output logic [AW:0]   out_count,
  output logic          in_ovf,
  output logic [15:0]   out_latch
);

  typedef enum logic [1:0] {
    IDLE,
    IN_WAIT,
    OUT_WAIT
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO = '0;

  state_t        state_q;
  logic [15:0]   in_mem  [DEPTH];
  logic [15:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wr_q, in_rd_q;
  logic [AW-1:0] out_wr_q, out_rd_q;
  logic [AW:0]   in_cnt_q, in_cnt_d;
  logic [AW:0]   out_cnt_q, out_cnt_d;
  logic [15:0]   in_data_q;
  logic [15:0]   latch_q;
  logic [15:0]   hold_q;
  logic          ack_q;
  logic          stall_q;
  logic          ovf_q;

  logic          in_full, in_empty;
  logic          out_full, out_empty;
  logic          in_push, in_pop;
  logic          out_take, out_push, out_pop;
  logic [15:0]   out_wdata;

  assign in_full   = (in_cnt_q == FULL);
  assign in_empty  = (in_cnt_q == ZERO);
  assign out_full  = (out_cnt_q == FULL);
  assign out_empty = (out_cnt_q == ZERO);

  // Decisions use the current counts; same-cycle host activity never helps the CPU.
  assign in_push  = host_push & ~in_full;
  assign in_pop   = ~in_empty &
                    (((state_q == IDLE) & cpu_in_req) |
                     (state_q == IN_WAIT));
  assign out_take = (state_q == IDLE) & cpu_out_req & ~cpu_in_req;
  assign out_push = ~out_full &
                    (out_take | (state_q == OUT_WAIT));
  assign out_pop  = host_pop & ~out_empty;
  assign out_wdata = (state_q == OUT_WAIT) ? hold_q : cpu_out_data;

  always_comb begin
    in_cnt_d  = in_cnt_q + {ZERO[AW-1:0], in_push}
                         - {ZERO[AW-1:0], in_pop};
    out_cnt_d = out_cnt_q + {ZERO[AW-1:0], out_push}
                          - {ZERO[AW-1:0], out_pop};
  end

  always_ff @(posedge clk) begin
    if (in_push)
      in_mem[in_wr_q] <= host_wdata;
    if (out_push)
      out_mem[out_wr_q] <= out_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      in_data_q <= '0;
      latch_q   <= '0;
      hold_q    <= '0;
      ack_q     <= 1'b0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ack_q     <= in_pop;
      if (in_push)
        in_wr_q <= in_wr_q + 1'b1;
      if (in_pop) begin
        in_rd_q   <= in_rd_q + 1'b1;
        in_data_q <= in_mem[in_rd_q];
      end
      if (host_push & in_full)
        ovf_q <= 1'b1;
      if (out_push) begin
        out_wr_q <= out_wr_q + 1'b1;
        latch_q  <= out_wdata;
      end
      if (out_pop)
        out_rd_q <= out_rd_q + 1'b1;
      if (out_take & out_full)
        hold_q <= cpu_out_data;

      unique case (state_q)
        IDLE: begin
          if (cpu_in_req & in_empty) begin
            state_q <= IN_WAIT;
            stall_q <= 1'b1;
          end else if (out_take & out_full) begin
            state_q <= OUT_WAIT;
            stall_q <= 1'b1;
          end
        end
        IN_WAIT: begin
          if (!in_empty) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
        end
        OUT_WAIT: begin
          if (!out_full) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_in_data = in_data_q;
  assign cpu_in_ack  = ack_q;
  assign cpu_stall   = stall_q;
  assign host_rdata  = out_mem[out_rd_q];
  assign host_rvalid = ~out_empty;
  assign in_count    = in_cnt_q;
  assign out_count   = out_cnt_q;
  assign in_ovf      = ovf_q;
  assign out_latch   = latch_q;

endmodule
